// File: rtl/cpu16_alu_pkg.sv
// cpu16_alu_pkg: shared types and constants for the cpu16 ALU sequencer
package cpu16_alu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} seq_state_t;
  typedef enum logic {CMD_ALU, CMD_MUL} seq_cmd_t;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_AND = 5'd22;
  localparam logic [4:0] OP_OR  = 5'd23;
  localparam logic [4:0] OP_XOR = 5'd24;
  localparam logic [4:0] OP_NOT = 5'd25;
  localparam logic [4:0] OP_SHL = 5'd26;
  localparam logic [4:0] OP_SHR = 5'd27;
  localparam int MUL_ITERS = 16;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: valid/ready request and response channels of the ALU sequencer
interface alu_sequencer_if #(parameter int WIDTH = 16);
  import cpu16_alu_pkg::*;
  logic             req_valid;
  logic             req_ready;
  seq_cmd_t         req_cmd;
  logic [4:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_lo;
  logic [WIDTH-1:0] rsp_hi;
  logic             rsp_cond_met;
  modport master (
    output req_valid, req_cmd, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cond_met
  );
  modport slave (
    input  req_valid, req_cmd, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cond_met
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences the shared ALU, runs shift-add multiply and owns the Z/C flags
module alu_sequencer
  import cpu16_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic             flag_z,
  output logic             flag_c,
  input  logic             flag_wr,
  input  logic             flag_wr_z,
  input  logic             flag_wr_c,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  output logic             alu_en,
  output logic             alu_z_in,
  output logic             alu_c_in,
  input  logic [WIDTH:0]   alu_out,
  input  logic             alu_z_out,
  input  logic             alu_c_out,
  input  logic             alu_cond
);
  localparam logic [3:0] CNT_LAST = 4'(MUL_ITERS - 1);
  seq_state_t         state_q;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [3:0]         cnt_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_lo_q;
  logic [WIDTH-1:0]   rsp_hi_q;
  logic               cond_q;
  logic               z_q;
  logic               c_q;
  logic [2*WIDTH-1:0] acc_d;
  // During MUL a_q holds the multiplicand and b_q doubles as the low accumulator word
  assign acc_d = {alu_out, b_q[WIDTH-1:1]};
  assign bus.req_ready    = state_q == S_IDLE;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_lo       = rsp_lo_q;
  assign bus.rsp_hi       = rsp_hi_q;
  assign bus.rsp_cond_met = cond_q;
  assign busy     = state_q != S_IDLE;
  assign flag_z   = z_q;
  assign flag_c   = c_q;
  assign alu_z_in = z_q;
  assign alu_c_in = c_q;
  // ALU drive: command operands in EXEC, accumulator step in MUL, idle otherwise
  always_comb begin
    alu_en = state_q == S_EXEC || state_q == S_MUL;
    alu_a  = state_q == S_EXEC ? a_q : state_q == S_MUL ? hi_q : '0;
    alu_b  = state_q == S_EXEC ? b_q : state_q == S_MUL && b_q[0] ? a_q : '0;
    alu_op = state_q == S_EXEC ? op_q : OP_ADD;
  end
  // Sequencer FSM with registered response and flags; a direct flag load has the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      cond_q      <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          a_q     <= bus.req_a;
          b_q     <= bus.req_b;
          hi_q    <= '0;
          cnt_q   <= '0;
          state_q <= bus.req_cmd == CMD_MUL ? S_MUL : S_EXEC;
        end
        S_EXEC: begin
          rsp_lo_q    <= alu_out[WIDTH-1:0];
          rsp_hi_q    <= {{(WIDTH-1){1'b0}}, alu_out[WIDTH]};
          cond_q      <= alu_cond;
          z_q         <= alu_cond ? alu_z_out : z_q;
          c_q         <= alu_cond ? alu_c_out : c_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_MUL: begin
          {hi_q, b_q} <= acc_d;
          cnt_q       <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            rsp_lo_q    <= acc_d[WIDTH-1:0];
            rsp_hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            cond_q      <= 1'b1;
            z_q         <= acc_d == '0;
            c_q         <= acc_d[2*WIDTH-1:WIDTH] != '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        default: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
      if (flag_wr) begin
        z_q <= flag_wr_z;
        c_q <= flag_wr_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with a behavioural ALU and product model
module tb_alu_sequencer;
  import cpu16_alu_pkg::*;
  typedef struct packed {logic [16:0] out; logic z; logic c; logic cond;} alu_res_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_z, flag_c, busy;
  logic        flag_wr = 1'b0, flag_wr_z = 1'b0, flag_wr_c = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic        alu_en, alu_z_in, alu_c_in;
  logic [16:0] alu_out;
  logic        alu_z_out, alu_c_out, alu_cond;
  alu_res_t    ar;
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_z = 1'b0;
  logic        exp_c = 1'b0;
  alu_sequencer_if bus();
  alu_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .flag_z(flag_z), .flag_c(flag_c),
    .flag_wr(flag_wr), .flag_wr_z(flag_wr_z), .flag_wr_c(flag_wr_c),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_z_in(alu_z_in), .alu_c_in(alu_c_in), .alu_out(alu_out),
    .alu_z_out(alu_z_out), .alu_c_out(alu_c_out), .alu_cond(alu_cond)
  );
  always #5 clk = ~clk;
  // Stand-in for the cpu16 ALU; ops 4..7 are conditional adds on Z, !Z, C, !C
  function automatic alu_res_t alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic zi, input logic ci);
    alu_res_t r;
    logic [16:0] s;
    case (op)
      5'd1:   s = {1'b0, a} - {1'b0, b};
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      OP_XOR: s = {1'b0, a ^ b};
      OP_NOT: s = {1'b0, ~a};
      OP_SHL: s = {a, 1'b0};
      OP_SHR: s = {a[0], 1'b0, a[15:1]};
      5'd2, 5'd3, 5'd28, 5'd29, 5'd30, 5'd31: s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      default: s = {1'b0, a} + {1'b0, b};
    endcase
    r.out  = s;
    r.z    = s[15:0] == 16'd0;
    r.c    = s[16];
    r.cond = op == 5'd4 ? zi : op == 5'd5 ? !zi : op == 5'd6 ? ci : op == 5'd7 ? !ci : 1'b1;
    return r;
  endfunction
  always_comb begin
    ar        = alu_f(alu_op, alu_a, alu_b, alu_z_in, alu_c_in);
    alu_out   = ar.out;
    alu_z_out = ar.z;
    alu_c_out = ar.c;
    alu_cond  = ar.cond;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load_flags(input logic z, input logic c);
    flag_wr = 1'b1; flag_wr_z = z; flag_wr_c = c;
    @(posedge clk); #1;
    flag_wr = 1'b0;
    exp_z = z; exp_c = c;
    check("flag_load", 32'({flag_z, flag_c}), 32'({z, c}));
  endtask
  task automatic run_cmd(input logic cmd, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit fw);
    alu_res_t r;
    logic [31:0] p;
    logic [15:0] elo, ehi, eb;
    logic econd, fwz, fwc;
    int lat, bsy, w;
    r   = alu_f(op, a, b, exp_z, exp_c);
    p   = 32'(a) * 32'(b);
    fwz = 1'($urandom);
    fwc = 1'($urandom);
    elo   = cmd ? p[15:0] : r.out[15:0];
    ehi   = cmd ? p[31:16] : {15'd0, r.out[16]};
    econd = cmd ? 1'b1 : r.cond;
    eb    = cmd ? (b[0] ? a : 16'd0) : b;
    bus.req_valid = 1'b1; bus.req_cmd = cmd ? CMD_MUL : CMD_ALU;
    bus.req_op = op; bus.req_a = a; bus.req_b = b;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
    check("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("alu_ab", {alu_a, alu_b}, {cmd ? 16'd0 : a, eb});
    check("alu_ctl", 32'({alu_en, alu_op, alu_z_in, alu_c_in}), 32'({1'b1, cmd ? 5'd0 : op, exp_z, exp_c}));
    if (fw) begin flag_wr = 1'b1; flag_wr_z = fwz; flag_wr_c = fwc; end
    if (!cmd) begin
      if (r.cond) begin exp_z = r.z; exp_c = r.c; end
      if (fw) begin exp_z = fwz; exp_c = fwc; end
    end else begin
      exp_z = p == 32'd0;
      exp_c = p[31:16] != 16'd0;
    end
    lat = 0; bsy = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      flag_wr = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), cmd ? 32'd16 : 32'd1);
    check("busy_cycles", 32'(bsy), 32'(lat));
    check("rsp_data", {bus.rsp_hi, bus.rsp_lo}, {ehi, elo});
    check("rsp_cond", 32'(bus.rsp_cond_met), 32'(econd));
    check("flags", 32'({flag_z, flag_c}), 32'({exp_z, exp_c}));
    check("resp_idle", 32'({bus.req_ready, busy, alu_en, alu_op, alu_a, alu_b}), 32'({1'b0, 1'b1, 1'b0, 5'd0, 32'd0}));
    bus.req_valid = hold > 0;
    bus.req_cmd = CMD_ALU; bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ctl", 32'({bus.req_ready, bus.rsp_valid, busy}), 32'b011);
      check("hold_rsp", {bus.rsp_hi, bus.rsp_lo}, {ehi, elo});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("handshake", 32'({bus.rsp_valid, busy, bus.req_ready}), 32'b001);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = CMD_ALU; bus.req_op = 5'd0;
    bus.req_a = 16'd0; bus.req_b = 16'd0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", 32'({bus.req_ready, bus.rsp_valid, busy, bus.rsp_cond_met, flag_z, flag_c}), 32'b100000);
    check("reset_rsp", {bus.rsp_hi, bus.rsp_lo}, 32'd0);
    check("reset_alu", 32'({alu_en, alu_op, alu_a, alu_b}), 32'd0);
    rst_n = 1'b1;
    run_cmd(1'b0, OP_ADD, 16'hFFFF, 16'h0001, 0, 1'b0);
    load_flags(1'b0, 1'b1);
    run_cmd(1'b0, 5'd4, 16'h1111, 16'h2222, 0, 1'b0);
    run_cmd(1'b1, 5'd0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_cmd(1'b1, 5'd0, 16'h1234, 16'h0000, 0, 1'b0);
    run_cmd(1'b1, 5'd0, 16'h0100, 16'h0100, 0, 1'b0);
    run_cmd(1'b0, OP_XOR, 16'hA5A5, 16'h5A5A, 5, 1'b0);
    run_cmd(1'b0, OP_ADD, 16'h8000, 16'h8000, 1, 1'b1);
    run_cmd(1'b0, 5'd30, 16'h0003, 16'h0004, 0, 1'b0);
    bus.req_valid = 1'b1; bus.req_cmd = CMD_MUL; bus.req_a = 16'hBEEF; bus.req_b = 16'hCAFE;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'({busy, bus.rsp_valid}), 32'b10);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 32'({bus.req_ready, bus.rsp_valid, busy, bus.rsp_cond_met, flag_z, flag_c}), 32'b100000);
    check("async_rst_alu", 32'({alu_en, alu_op, alu_a, alu_b}), 32'd0);
    check("async_rst_rsp", {bus.rsp_hi, bus.rsp_lo}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_z = 1'b0; exp_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("no_rsp_after_rst", 32'({bus.rsp_valid, busy}), 32'd0);
    end
    run_cmd(1'b0, OP_ADD, 16'h0010, 16'h0020, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) load_flags(1'($urandom), 1'($urandom));
      run_cmd($urandom_range(0, 3) == 0, 5'($urandom), 16'($urandom), $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 3)) : 16'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 5) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequences the shared 16-bit ALU for the cpu16 core. Accepts one command at a time over a valid/ready request channel. Single-cycle ALU commands are passed straight through; unsigned 16x16→32 multiply is run as a 16-step shift-add loop on the ALU's add path. Owns the architectural Z/C flag register, feeds it to the ALU, and returns results over a valid/ready response channel.

## Interface
Parameters:
- WIDTH, 16, datapath width; the only supported value.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  sequencer can accept a command; high only in IDLE.
- req_cmd  in  1  command kind: 0 = ALU, 1 = MUL.
- req_op  in  5  ALU opcode; used only when req_cmd = 0.
- req_a, req_b  in  16 each  operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_lo, rsp_hi  out  16 each  result low/high words.
- rsp_cond_met  out  1  ALU condition met; always 1 for MUL.
- flag_z, flag_c  out  1 each  architectural flags.
- flag_wr, flag_wr_z, flag_wr_c  in  1 each  direct flag load (interrupt return).
- busy  out  1  high in any state other than IDLE.
- alu_a, alu_b  out  16 each  ALU operands.
- alu_op  out  5  ALU opcode.
- alu_en  out  1  ALU enable.
- alu_z_in, alu_c_in  out  1 each  flags presented to the ALU; always equal to flag_z and flag_c.
- alu_out  in  17  ALU result; bit 16 is carry.
- alu_z_out, alu_c_out, alu_cond  in  1 each  ALU flag outputs and condition result.

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch cmd, op, a and b.
  - ALU command → EXEC.
  - MUL → MUL with mcand = a, acc_hi = 0, acc_lo = b, cnt = 0.
- EXEC (one cycle):
  - Drive alu_a = a, alu_b = b, alu_op = op, alu_en = 1.
  - Capture rsp_lo = alu_out[15:0], rsp_hi = {15'b0, alu_out[16]}, rsp_cond_met = alu_cond.
  - If alu_cond = 1: flag_z ← alu_z_out, flag_c ← alu_c_out. Otherwise flags are unchanged.
  - Next state RESP.
- MUL (16 cycles):
  - Drive alu_a = acc_hi, alu_b = acc_lo[0] ? mcand : 0, alu_op = 5'd0 (plain add), alu_en = 1.
  - Each cycle: {acc_hi, acc_lo} ← {alu_out[16:0], acc_lo[15:1]}, and cnt increments.
  - After cnt = 15: rsp_lo = acc_lo, rsp_hi = acc_hi, rsp_cond_met = 1, flag_z = (32-bit product == 0), flag_c = (acc_hi != 0). Next state RESP.
- RESP: rsp_valid = 1 and all rsp_* stay stable until rsp_ready. On rsp_ready, return to IDLE.
- In IDLE and RESP: alu_en = 0 and alu_a / alu_b / alu_op = 0.
- flag_wr loads flag_z / flag_c in any state. If it coincides with an EXEC or MUL flag update in the same cycle, flag_wr wins.
- Opcodes 28–31 are not checked; they are forwarded to the ALU like any other opcode.

## Timing
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_lo/rsp_hi 0; rsp_cond_met 0; flag_z/flag_c 0; busy 0; all alu_* outputs 0.
- Reset mid-EXEC or mid-MUL: the command is abandoned, no response is produced, and flags return to 0.
- If a request is accepted on edge t0:
  - ALU command: rsp_valid is high from edge t0+1.
  - MUL: rsp_valid is high from edge t0+16.
- With rsp_ready held high, back-to-back throughput is one ALU command per 3 cycles (IDLE, EXEC, RESP).
- No request is accepted while rsp_valid is high. No request is accepted in the same cycle as the rsp_ready handshake; the next accept is at the earliest one edge later.
- busy = (state != IDLE), combinational from the state register.
- rsp_* and flag_* are driven from registers. alu_* are combinational from state and latched operands.

## Structure
- Package cpu16_alu_pkg:
  - seq_state_t enum.
  - seq_cmd_t enum: CMD_ALU, CMD_MUL.
  - ALU opcode constants: OP_ADD = 5'd0, OP_AND = 5'd22 … OP_SHR = 5'd27.
  - MUL_ITERS = 16.
- Single module with no sub-module. The existing ALU is instantiated beside it at the datapath top, not inside it.

## Test plan
- Reset, then ALU OP_ADD with a=0xFFFF, b=0x0001 → at t0+1: rsp_lo=0x0000, rsp_hi=0x0001, flag_z=1, flag_c=1, rsp_cond_met=1.
- Load flags with flag_wr (Z=0), then issue conditional op 5'd4 (add-if-zero) → rsp_cond_met=0 and flags stay unchanged.
- MUL a=0xFFFF, b=0xFFFF → at t0+16: rsp_hi=0xFFFE, rsp_lo=0x0001, flag_c=1, flag_z=0. Also check that busy is high for exactly 16 cycles.
- MUL a=0x1234, b=0x0000 → product 0, flag_z=1, flag_c=0. MUL a=0x0100, b=0x0100 → rsp_hi=0x0001, rsp_lo=0x0000.
- Hold rsp_ready=0 for 5 cycles with req_valid held high → req_ready stays 0 and rsp_* stay stable; the next command is accepted only after the handshake.
- Assert rst_n low at cycle 8 of a MUL → all outputs return to their reset values, no rsp_valid is produced, and a following ALU command completes correctly.
